// File: rtl/wireframe_draw_pkg.sv
// Shared vertex/line types, screen geometry and FSM states for wireframe_draw.
// Optional macro WIREFRAME_CLEAR_EN adds the StClear state (framebuffer sweep).
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef HEIGHT
`define HEIGHT 24
`endif
`ifndef WIREFRAME_ADDR_SIZE
`define WIREFRAME_ADDR_SIZE 10
`endif

package wireframe_draw_pkg;

    localparam int WF_WIDTH     = `WIDTH;
    localparam int WF_HEIGHT    = `HEIGHT;
    localparam int WF_ADDR_SIZE = `WIREFRAME_ADDR_SIZE;

    typedef struct packed {
        shortint x;
        shortint y;
        shortint z;
    } Point3D;

    typedef struct packed {
        Point3D p;
        Point3D q;
        Point3D r;
    } Triangle3D;

    // dx >= 0, dy <= 0; sx/sy hold +1 or -1 as 16-bit two's complement
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] sx;
        logic [15:0] sy;
        logic [17:0] dx;
        logic [17:0] dy;
        logic [17:0] err;
    } LineState;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StDraw,
        StDone
`ifdef WIREFRAME_CLEAR_EN
        , StClear
`endif
    } wf_state_e;

endpackage

// File: rtl/wireframe_draw_bresenham_step.sv
// One Bresenham step: next LineState from the current one, plus end-of-line flag.
// Purely combinational; the caller decides whether to register o_next.
module wireframe_draw_bresenham_step
    import wireframe_draw_pkg::*;
(
    input  LineState i_ls,
    output LineState o_next,
    output logic     o_at_end
);

    logic signed [18:0] w_e2;
    logic signed [18:0] w_dx;
    logic signed [18:0] w_dy;
    logic signed [17:0] w_err;
    logic               w_step_x;
    logic               w_step_y;

    always_comb begin
        w_e2     = {i_ls.err, 1'b0};
        w_dx     = {i_ls.dx[17], i_ls.dx};
        w_dy     = {i_ls.dy[17], i_ls.dy};
        o_at_end = (i_ls.x == i_ls.x1) && (i_ls.y == i_ls.y1);
        // Both decisions use the pre-update error term
        w_step_x = !o_at_end && (w_e2 >= w_dy);
        w_step_y = !o_at_end && (w_e2 <= w_dx);
        w_err    = i_ls.err;
        o_next   = i_ls;
        if (w_step_x) begin
            w_err    = w_err + i_ls.dy;
            o_next.x = i_ls.x + i_ls.sx;
        end
        if (w_step_y) begin
            w_err    = w_err + i_ls.dx;
            o_next.y = i_ls.y + i_ls.sy;
        end
        o_next.err = w_err;
    end

endmodule

// File: rtl/wireframe_draw.sv
// Rasterizes the three edges of a triangle into a 1-bit wireframe SRAM, one pixel per clock.
// Define WIREFRAME_CLEAR_EN to sweep the whole framebuffer to 0 before drawing.
module wireframe_draw
    import wireframe_draw_pkg::*;
#(
    parameter int WIDTH  = WF_WIDTH,
    parameter int HEIGHT = WF_HEIGHT,
    parameter int ADDR_W = WF_ADDR_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  Triangle3D         i_ver,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_wdata,
    output logic              o_sram_we
);

    wf_state_e          r_state, w_state_nxt;
    logic [1:0]         r_edge, w_edge_nxt;
    logic [15:0]        r_vx [3];
    logic [15:0]        r_vy [3];
    LineState           r_ls, w_ls_nxt, w_setup_ls, w_step_ls;
    logic               w_at_end;
    logic               w_capture;
    logic signed [15:0] w_x0, w_y0, w_x1, w_y1;
    logic signed [17:0] w_ddx, w_ddy, w_adx, w_ady;
    logic               w_x_ok, w_y_ok;
    logic               w_unused_z;

`ifdef WIREFRAME_CLEAR_EN
    localparam logic [ADDR_W-1:0] ClrLast = ADDR_W'(WIDTH * HEIGHT - 1);
    logic [ADDR_W-1:0] r_clr, w_clr_nxt;
`endif

    assign w_unused_z = ^{i_ver.p.z, i_ver.q.z, i_ver.r.z};
    assign w_capture  = (r_state == StIdle) && i_start;

    wireframe_draw_bresenham_step u_step (
        .i_ls     (r_ls),
        .o_next   (w_step_ls),
        .o_at_end (w_at_end)
    );

    // Edge 0: p->q, edge 1: q->r, edge 2: r->p
    always_comb begin
        case (r_edge)
            2'd0: begin
                w_x0 = r_vx[0]; w_y0 = r_vy[0]; w_x1 = r_vx[1]; w_y1 = r_vy[1];
            end
            2'd1: begin
                w_x0 = r_vx[1]; w_y0 = r_vy[1]; w_x1 = r_vx[2]; w_y1 = r_vy[2];
            end
            default: begin
                w_x0 = r_vx[2]; w_y0 = r_vy[2]; w_x1 = r_vx[0]; w_y1 = r_vy[0];
            end
        endcase
        w_ddx = {{2{w_x1[15]}}, w_x1} - {{2{w_x0[15]}}, w_x0};
        w_ddy = {{2{w_y1[15]}}, w_y1} - {{2{w_y0[15]}}, w_y0};
        w_adx = w_ddx[17] ? -w_ddx : w_ddx;
        w_ady = w_ddy[17] ? -w_ddy : w_ddy;
        w_setup_ls.x   = w_x0;
        w_setup_ls.y   = w_y0;
        w_setup_ls.x1  = w_x1;
        w_setup_ls.y1  = w_y1;
        w_setup_ls.sx  = (w_x0 < w_x1) ? 16'h0001 : 16'hFFFF;
        w_setup_ls.sy  = (w_y0 < w_y1) ? 16'h0001 : 16'hFFFF;
        w_setup_ls.dx  = w_adx;
        w_setup_ls.dy  = -w_ady;
        w_setup_ls.err = w_adx - w_ady;
    end

    // x[15]/y[15] flag negative coordinates; the walk continues while clipped
    assign w_x_ok = !r_ls.x[15] && (32'(r_ls.x) < 32'(WIDTH));
    assign w_y_ok = !r_ls.y[15] && (32'(r_ls.y) < 32'(HEIGHT));

    always_comb begin
        w_state_nxt = r_state;
        w_edge_nxt  = r_edge;
        w_ls_nxt    = r_ls;
`ifdef WIREFRAME_CLEAR_EN
        w_clr_nxt   = r_clr;
`endif
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_sram_we    = 1'b0;
        o_sram_wdata = 1'b0;
        o_sram_addr  = '0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_edge_nxt = 2'd0;
`ifdef WIREFRAME_CLEAR_EN
                    w_clr_nxt   = '0;
                    w_state_nxt = StClear;
`else
                    w_state_nxt = StSetup;
`endif
                end
            end
`ifdef WIREFRAME_CLEAR_EN
            StClear: begin
                o_busy      = 1'b1;
                o_sram_we   = 1'b1;
                o_sram_addr = r_clr;
                w_clr_nxt   = r_clr + 1'b1;
                if (r_clr == ClrLast) begin
                    w_state_nxt = StSetup;
                end
            end
`endif
            StSetup: begin
                o_busy      = 1'b1;
                w_ls_nxt    = w_setup_ls;
                w_state_nxt = StDraw;
            end
            StDraw: begin
                o_busy       = 1'b1;
                o_sram_wdata = 1'b1;
                o_sram_we    = w_x_ok && w_y_ok;
                o_sram_addr  = ADDR_W'(r_ls.y) * ADDR_W'(WIDTH) + ADDR_W'(r_ls.x);
                if (w_at_end) begin
                    if (r_edge == 2'd2) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_edge_nxt  = r_edge + 2'd1;
                        w_state_nxt = StSetup;
                    end
                end else begin
                    w_ls_nxt = w_step_ls;
                end
            end
            StDone: begin
                o_done = 1'b1;
                if (!i_start) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_edge  <= '0;
            r_ls    <= '0;
            for (int i = 0; i < 3; i++) begin
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
`ifdef WIREFRAME_CLEAR_EN
            r_clr   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_edge  <= w_edge_nxt;
            r_ls    <= w_ls_nxt;
`ifdef WIREFRAME_CLEAR_EN
            r_clr   <= w_clr_nxt;
`endif
            if (w_capture) begin
                r_vx[0] <= i_ver.p.x;
                r_vy[0] <= i_ver.p.y;
                r_vx[1] <= i_ver.q.x;
                r_vy[1] <= i_ver.q.y;
                r_vx[2] <= i_ver.r.x;
                r_vy[2] <= i_ver.r.y;
            end
        end
    end

endmodule

// File: tb/tb_wireframe_draw.sv
// Self-checking bench for wireframe_draw: per-cycle expectation queue from an integer line model,
// SRAM shadow bitmap, plus literal checks on latency, clipping, degenerate edges and reset.
module tb_wireframe_draw;
    import wireframe_draw_pkg::*;

    localparam int W    = WF_WIDTH;
    localparam int H    = WF_HEIGHT;
    localparam int NPIX = W * H;
`ifdef WIREFRAME_CLEAR_EN
    localparam int  CLR    = NPIX;
    localparam bit  PREVAL = 1'b1;
`else
    localparam int  CLR    = 0;
    localparam bit  PREVAL = 1'b0;
`endif
    localparam int LIMIT = NPIX + 2000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    Triangle3D               ver;
    logic                    busy, done, wd, we;
    logic [WF_ADDR_SIZE-1:0] addr;

    always #5 clk = ~clk;

    wireframe_draw dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_ver        (ver),
        .o_busy       (busy),
        .o_done       (done),
        .o_sram_addr  (addr),
        .o_sram_wdata (wd),
        .o_sram_we    (we)
    );

    typedef struct {
        bit busy;
        bit done;
        bit we;
        bit wd;
        int addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t ce;
    bit   mem    [NPIX];
    bit   ref_bm [NPIX];
    int   total = 0;
    int   bad = 0;
    int   busy_cnt = 0;
    int   wr_cnt = 0;
    int   off_cnt = 0;
    int   exp_busy = 0;
    int   watch_addr = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic void push(input bit b, input bit d, input bit w, input bit v, input int a);
        exp_t e;
        e.busy = b; e.done = d; e.we = w; e.wd = v; e.addr = a;
        exp_q.push_back(e);
        if (b) exp_busy++;
    endfunction

    // Reference line walk in plain integers; records every DRAW cycle and the set pixels
    function automatic void gen_line(input int x0, input int y0, input int x1, input int y1);
        int dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        int dy = (y1 > y0) ? y0 - y1 : y1 - y0;
        int sx = (x0 < x1) ? 1 : -1;
        int sy = (y0 < y1) ? 1 : -1;
        int err = dx + dy;
        int x = x0;
        int y = y0;
        int e2;
        bit inb;
        forever begin
            inb = (x >= 0) && (x < W) && (y >= 0) && (y < H);
            push(1'b1, 1'b0, inb, 1'b1, inb ? y * W + x : 0);
            if (inb) ref_bm[y * W + x] = 1'b1;
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    // Per-cycle compare against the expectation queue
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            chk("busy", int'(busy), int'(ce.busy));
            chk("done", int'(done), int'(ce.done));
            chk("we", int'(we), int'(ce.we));
            if (ce.we) begin
                chk("addr", int'(addr), ce.addr);
                chk("wdata", int'(wd), int'(ce.wd));
            end
        end
    end

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (we && wd) begin
            wr_cnt++;
            if (int'(addr) != watch_addr) off_cnt++;
        end
    end

    always @(posedge clk) begin
        if (we) mem[addr] <= wd;
    end

    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int hold);
        int n;
        int diff;
        @(posedge clk); #1;
        exp_q.delete();
        exp_busy = 0;
        for (int i = 0; i < NPIX; i++) begin
            ref_bm[i] = 1'b0;
            mem[i]    = PREVAL;
        end
        push(1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < CLR; i++) push(1'b1, 1'b0, 1'b1, 1'b0, i);
        push(1'b1, 1'b0, 1'b0, 1'b0, 0);
        gen_line(ax, ay, bx, by);
        push(1'b1, 1'b0, 1'b0, 1'b0, 0);
        gen_line(bx, by, cx, cy);
        push(1'b1, 1'b0, 1'b0, 1'b0, 0);
        gen_line(cx, cy, ax, ay);
        for (int i = 0; i <= hold; i++) push(1'b0, 1'b1, 1'b0, 1'b0, 0);
        busy_cnt = 0; wr_cnt = 0; off_cnt = 0;
        ver.p.x = shortint'(ax); ver.p.y = shortint'(ay); ver.p.z = shortint'($urandom);
        ver.q.x = shortint'(bx); ver.q.y = shortint'(by); ver.q.z = shortint'($urandom);
        ver.r.x = shortint'(cx); ver.r.y = shortint'(cy); ver.r.z = shortint'($urandom);
        start = 1'b1;
        @(posedge clk); #1;
        ver = Triangle3D'({$urandom, $urandom, $urandom});
        n = 0;
        while (exp_q.size() != 0 && n < LIMIT) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        chk("busy_cycles", busy_cnt, exp_busy);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_held", int'(done), 1);
        @(negedge clk);
        chk("idle_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        diff = 0;
        for (int i = 0; i < NPIX; i++) if (mem[i] != ref_bm[i]) diff++;
        chk("bitmap_diff", diff, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int diff;
        int snap;
        ver = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_wdata", int'(wd), 0);
        @(negedge clk);
        rst = 1'b0;

        // Full-screen right triangle
        run_tri(0, 0, 0, H - 1, W - 1, H - 1, 3);
        chk("tri_cycles", busy_cnt, CLR + 3 + H + W + ((W > H) ? W : H));

        // Degenerate triangle
        watch_addr = 20 * W + 10;
        run_tri(10, 20, 10, 20, 10, 20, 0);
        chk("deg_writes", wr_cnt, 3);
        chk("deg_off_addr", off_cnt, 0);
        chk("deg_cycles", busy_cnt, CLR + 6);
        watch_addr = -1;

        // Clipping at the left edge
        run_tri(-5, 3, 4, 3, 4, 3, 0);
        chk("clip_writes", wr_cnt, 11);
        diff = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (mem[i] != ((i >= 3 * W) && (i <= 3 * W + 4))) diff++;
        end
        chk("clip_bits", diff, 0);

        // Asynchronous reset in the middle of edge 0
        @(posedge clk); #1;
        ver.p.x = 16'sd0;  ver.p.y = 16'sd0;  ver.p.z = 16'sd0;
        ver.q.x = 16'(W - 1); ver.q.y = 16'sd5; ver.q.z = 16'sd0;
        ver.r.x = 16'sd3;  ver.r.y = 16'(H - 1); ver.r.z = 16'sd0;
        start = 1'b1;
        repeat (CLR + 6) @(posedge clk);
        #2;
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_we", int'(we), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_we", int'(we), 0);
        chk("mid_rst_addr", int'(addr), 0);
        chk("mid_rst_wdata", int'(wd), 0);
        chk("mid_rst_done", int'(done), 0);
        start = 1'b0;
        snap = wr_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_writes", wr_cnt - snap, 0);
        chk("post_rst_busy", int'(busy), 0);

        // Randomized triangles, some partly off-screen
        for (int k = 0; k < 6; k++) begin
            run_tri(int'($urandom_range(0, W + 15)) - 8, int'($urandom_range(0, H + 15)) - 8,
                    int'($urandom_range(0, W + 15)) - 8, int'($urandom_range(0, H + 15)) - 8,
                    int'($urandom_range(0, W + 15)) - 8, int'($urandom_range(0, H + 15)) - 8,
                    int'($urandom_range(0, 3)));
        end
        run_tri(int'($urandom_range(0, 120)) - 60, int'($urandom_range(0, 120)) - 60,
                int'($urandom_range(0, 120)) - 60, int'($urandom_range(0, 120)) - 60,
                int'($urandom_range(0, 120)) - 60, int'($urandom_range(0, 120)) - 60, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wireframe_draw.md
Name: wireframe_draw

Overview:
- Rasterizes the three edges (p→q, q→r, r→p) of one Triangle3D into the 1-bit wireframe SRAM.
- Sits directly upstream of colorloop: colorloop reads this wireframe bitmap via sram_addr/sram_val to find fill spans.
- Integer Bresenham, one pixel per clock; z is ignored.
- Off-screen pixels are clipped, not wrapped.

Parameters:
- WIDTH, `WIDTH, screen width in pixels; also the row stride of the wireframe address.
- HEIGHT, `HEIGHT, screen height in pixels.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to draw; level; sampled only in IDLE.
- ver  in  Triangle3D  vertices (shortint x/y/z); captured on accepted start.
- busy  out  1  high from start acceptance until DONE is entered.
- done  out  1  high in DONE; held until start drops.
- sram_addr  out  `WIREFRAME_ADDR_SIZE  write address, y*WIDTH+x.
- sram_wdata  out  1  write data; 1 while drawing, 0 while clearing.
- sram_we  out  1  write strobe; single-cycle per pixel.

Behaviour:
- Reset values: state=IDLE; busy=0, done=0, sram_we=0, sram_addr=0, sram_wdata=0; all internal registers 0.
- Reset is asynchronous and may arrive mid-draw. It aborts to IDLE with no further writes; partially drawn pixels remain in SRAM.
- Latency: each edge costs 1 SETUP cycle plus N DRAW cycles, where N = max(|dx|,|dy|)+1. The DONE cycle follows the last DRAW cycle of edge 2.
- FSM:
  - IDLE: when start=1, latch ver, set edge index=0, busy=1, go to SETUP (or CLEAR when the optional feature is compiled in).
  - SETUP: load x0/y0/x1/y1 for the current edge.
    - dx = |x1-x0|, dy = -|y1-y0|.
    - sx = (x0<x1)?+1:-1, sy = (y0<y1)?+1:-1.
    - err = dx+dy.
    - Go to DRAW.
  - DRAW: write pixel (x,y) this cycle.
    - If x==x1 && y==y1: edge complete. Edge index 0/1 → increment, go to SETUP. Edge index 2 → go to DONE.
    - Otherwise e2 = 2*err:
      - If e2 >= dy: err += dy, x += sx.
      - If e2 <= dx: err += dx, y += sy.
      - Both updates use the pre-update err.
  - DONE: done=1, busy=0, no writes. Go to IDLE when start=0. If start stays high, the block remains in DONE; this avoids redrawing during colorloop's start-held handshake.
- Arithmetic widths:
  - Coordinates: 16-bit signed.
  - dx, dy, err: 18-bit signed; e2: 19-bit signed. No overflow is possible for shortint inputs.
- Address: y*WIDTH+x, truncated to `WIREFRAME_ADDR_SIZE.
- Clipping: if x<0, x>=WIDTH, y<0 or y>=HEIGHT, then sram_we=0 for that cycle, but the walk still advances.
- Degenerate edge (x0==x1, y0==y1): exactly one DRAW cycle.
- Shared vertices are written twice; this is harmless because writes are idempotent.
- ver changes after acceptance are ignored.
- The block never reads SRAM.

Optional Feature:
- Macro: WIREFRAME_CLEAR_EN.
- Defined: an accepted start enters CLEAR first.
  - A counter sweeps addresses 0..WIDTH*HEIGHT-1, one per cycle, with sram_we=1 and sram_wdata=0.
  - This adds WIDTH*HEIGHT cycles, then the FSM goes to SETUP.
- Not defined: the CLEAR state and its counter are absent. The bench or upstream logic must pre-clear the SRAM.

Decomposition:
- Package defines_package.vh: Triangle3D/Point3D, `WIDTH, `HEIGHT, `WIREFRAME_ADDR_SIZE, and a new typedef LineState (x, y, x1, y1, sx, sy, dx, dy, err).
- Sub-module bresenham_step: combinational next-LineState plus an at_end flag. Instantiated once; the FSM, edge multiplexing, clipping and address generation stay in wireframe_draw.

Test Plan:
- Reset mid-DRAW (rst pulsed while busy=1) → outputs go to reset values within the same cycle; the next start draws correctly.
- Triangle p=(0,0), q=(0,HEIGHT-1), r=(WIDTH-1,HEIGHT-1) → pixels at x=0 all y, y=HEIGHT-1 all x, and the diagonal are set. Cycle count = 3 + HEIGHT + WIDTH + max(WIDTH,HEIGHT) from busy rise to done. No other bits are set.
- Degenerate p=q=r=(10,20) → exactly three writes, all to address 20*WIDTH+10; done follows 6 cycles after acceptance.
- Clipping: p=(-5,3), q=(4,3), r=(4,3) → addresses 3*WIDTH+0..3*WIDTH+4 are written. No write is issued for x<0, and no address wrap occurs.
- Handshake: start held high through done → no second draw, done stays 1. Drop start → IDLE next cycle. Raise start again → a fresh draw begins.
- With WIREFRAME_CLEAR_EN and SRAM prefilled to 1 → all addresses are 0 except the edge pixels, and the first edge write occurs after WIDTH*HEIGHT clear cycles.
